// File: rtl/canny_pkg.sv
// Shared types and helpers for the streaming Canny frame sequencer.
// Contents: sequencer state encoding, frame size function, counter-width
// helper and the default padding pixel value.
package canny_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned PAD_DEFAULT = 0;

  // Pixels per frame.
  function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Bits needed to hold 0..max_val (at least one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/canny_out_slice.sv
// One-entry output register for the Canny sequencer.
// Ports:
//   clk, rst         clock, async active-high reset
//   cap              load din/last_in into the register this edge
//   din, last_in     pixel and end-of-frame flag to load
//   m_ready          downstream ready
//   m_data, m_valid, m_last  registered stream output
//   room_c           register can take a new pixel this cycle (combinational)
module canny_out_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] din,
  input  logic              last_in,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              room_c
);

  // Empty, or the held pixel leaves on this edge.
  assign room_c = !m_valid | m_ready;

  // Capture has priority; the caller only captures when room_c is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (cap) begin
      m_data  <= din;
      m_valid <= 1'b1;
      m_last  <= last_in;
    end else if (m_valid & m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/canny_frame_seq.sv
// Frame sequencer for the streaming Canny core. Accepts an AXI-stream frame
// of IMG_W*IMG_H pixels, strobes a fixed-latency enable-stalled filter chain,
// drains the chain with PAD_VAL after the last pixel and presents the chain
// output as a registered stream with m_last on the final pixel.
// Optional feature macro: LAST_CHECK_EN (s_last checking, early frame end).
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_data/s_valid/s_last/s_ready   input stream
//   pipe_din/pipe_en         pixel and advance strobe into the chain
//   pipe_col/pipe_row/pipe_pad      coordinates of the injected pixel
//   pipe_dout                chain output, valid during the enable cycle
//   m_data/m_valid/m_last/m_ready   output stream
//   err_last                 sticky s_last mismatch flag
module canny_frame_seq
  import canny_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       IMG_W   = 512,
  parameter int unsigned       IMG_H   = 512,
  parameter int unsigned       LAT     = 1030,
  parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(PAD_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [DATA_W-1:0]               pipe_din,
  output logic                            pipe_en,
  output logic [cnt_w(IMG_W-1)-1:0]       pipe_col,
  output logic [cnt_w(IMG_H-1):0]         pipe_row,
  output logic                            pipe_pad,
  input  logic [DATA_W-1:0]               pipe_dout,
  output logic [DATA_W-1:0]               m_data,
  output logic                            m_valid,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic                            err_last
);

  localparam int unsigned N     = frame_pix(IMG_W, IMG_H);
  localparam int unsigned TOT   = N + LAT;
  localparam int unsigned CW    = cnt_w(TOT);
  localparam int unsigned COL_W = cnt_w(IMG_W - 1);
  localparam int unsigned ROW_W = cnt_w(IMG_H - 1) + 1;

  state_t            state, state_nx;
  logic [CW-1:0]     in_cnt, en_cnt, out_cnt;
  logic [CW-1:0]     in_base, en_base, out_base;
  logic [COL_W-1:0]  col, col_base;
  logic [ROW_W-1:0]  row, row_base;
  logic              room, fin, mode_in, drain_en, acc;
  logic              last_pix, early_last, frame_end, cap, cap_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state. A final output transfer may coincide with the next frame's
  // first pixel, so DRAIN can go straight to RUN (or DRAIN again for N==1).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (acc) state_nx = frame_end ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (frame_end) state_nx = ST_DRAIN;
      ST_DRAIN: if (fin) state_nx = acc ? (frame_end ? ST_DRAIN : ST_RUN) : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs to the input stream and the chain. Once the m_last transfer is
  // happening, the sequencer already behaves as idle for the input side.
  always_comb begin
    fin      = 1'b0;
    mode_in  = 1'b0;
    drain_en = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: mode_in = 1'b1;
      ST_DRAIN: begin
        fin      = m_valid & m_ready & m_last;
        mode_in  = fin;
        drain_en = !fin & room & (en_cnt < CW'(TOT));
      end
      default: mode_in = 1'b0;
    endcase
    s_ready  = !rst & mode_in & room;
    acc      = s_valid & s_ready;
    pipe_en  = acc | (!rst & drain_en);
    pipe_din = mode_in ? s_data : PAD_VAL;
    pipe_pad = !mode_in;
    pipe_col = col_base;
    pipe_row = row_base;
  end

  // Counter bases restart at zero in the cycle the previous frame completes.
  always_comb begin
    in_base    = fin ? '0 : in_cnt;
    en_base    = fin ? '0 : en_cnt;
    out_base   = fin ? '0 : out_cnt;
    col_base   = fin ? '0 : col;
    row_base   = fin ? '0 : row;
    last_pix   = acc & (in_base == CW'(N - 1));
    early_last = 1'b0;
`ifdef LAST_CHECK_EN
    early_last = acc & s_last & (in_base != CW'(N - 1));
`endif
    frame_end  = last_pix | early_last;
    cap        = pipe_en & (en_base >= CW'(LAT));
    cap_last   = (out_base == CW'(N - 1));
  end

  // Frame counters and pixel coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      en_cnt  <= '0;
      out_cnt <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      in_cnt  <= in_base + CW'(acc);
      en_cnt  <= en_base + CW'(pipe_en);
      out_cnt <= out_base + CW'(cap);
      if (pipe_en && col_base == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row_base + ROW_W'(1);
      end else if (pipe_en) begin
        col <= col_base + COL_W'(1);
        row <= row_base;
      end else begin
        col <= col_base;
        row <= row_base;
      end
    end
  end

`ifdef LAST_CHECK_EN
  logic err_q;

  // Set on s_last too early or missing on the last pixel; a frame's first
  // pixel clears it unless that pixel is itself in error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (acc) begin
      if (early_last | (last_pix & !s_last)) err_q <= 1'b1;
      else if (in_base == '0)                 err_q <= 1'b0;
    end
  end

  assign err_last = err_q;
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign err_last      = 1'b0;
`endif

  canny_out_slice #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .cap     (cap),
    .din     (pipe_dout),
    .last_in (cap_last),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .room_c  (room)
  );

endmodule
